// File: rtl/riscv_pkg.sv
// Shared definitions for the 64-bit RISC-V core's memory stage.
// Contents:
//   XLEN            datapath width
//   SZ_B..SZ_D      access-size encodings (byte, half, word, double)
//   mem_state_t     MEM-stage handshake FSM states
//   is_misaligned   natural-alignment test for an access
//   store_strobe    byte-enable pattern for a store within a doubleword
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } mem_state_t;

  // An access is misaligned when any address bit below its size is set.
  function automatic logic is_misaligned(input logic [2:0] a, input logic [1:0] size);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return a[0];
      SZ_W:    return |a[1:0];
      default: return |a;
    endcase
  endfunction

  function automatic logic [7:0] store_strobe(input logic [2:0] a, input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01 << a;
      SZ_H:    return 8'h03 << a;
      SZ_W:    return 8'h0F << a;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load data alignment and extension (combinational).
// Ports:
//   rdata     in   XLEN  whole doubleword returned by data memory
//   a         in   3     byte offset of the access within the doubleword
//   size      in   2     access size (SZ_B/H/W/D)
//   zero_ext  in   1     1 = zero-extend (LBU/LHU/LWU), 0 = sign-extend
//   result    out  XLEN  aligned, extended load value
module load_align_ext
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      a,
  input  logic [1:0]      size,
  input  logic            zero_ext,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  // Bring the addressed byte down to lane 0 before extending.
  assign shifted = rdata >> {a, 3'b000};

  always_comb begin
    result = shifted;
    case (size)
      SZ_B: result = zero_ext ? {56'd0, shifted[7:0]}
                              : {{56{shifted[7]}}, shifted[7:0]};
      SZ_H: result = zero_ext ? {48'd0, shifted[15:0]}
                              : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W: result = zero_ext ? {32'd0, shifted[31:0]}
                              : {{32{shifted[31]}}, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage of the 64-bit RISC-V core.
// Holds one instruction from EX, runs the data-memory req/gnt/rvalid
// handshake for loads and stores, aligns/extends load data and presents the
// result to the forwarding check and writeback.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   ex_valid_i / ex_ready_o           EX handshake (ready low stalls EX)
//   ex_rd_addr_i/_data_i/_wen_i       destination register, ALU result, write enable
//   ex_ram_req_i/_we_i/_addr_i        memory access request, store flag, byte address
//   ex_ram_wdata_i/_size_i/_unsigned_i store data, access size, zero-extend load
//   flush_i                           trap kill of the instruction in MEM
//   dmem_req_o/_we_o/_addr_o          data-memory request, write, doubleword address
//   dmem_wdata_o/_wstrb_o             replicated store data, byte enables
//   dmem_gnt_i/_rvalid_i/_rdata_i     grant, read-data valid, read data
//   mem_rd_addr_o/_data_o/_wen_o      MEM-stage result for forwarding and WB
//   wb_valid_o                        one instruction retires this cycle
//   misalign_o                        misaligned-access exception pulse
module mem_stage #(
  parameter int XLEN   = 64,
  parameter int RAM_AW = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [4:0]        ex_rd_addr_i,
  input  logic [XLEN-1:0]   ex_rd_data_i,
  input  logic              ex_rd_wen_i,
  input  logic              ex_ram_req_i,
  input  logic              ex_ram_we_i,
  input  logic [RAM_AW-1:0] ex_ram_addr_i,
  input  logic [XLEN-1:0]   ex_ram_wdata_i,
  input  logic [1:0]        ex_ram_size_i,
  input  logic              ex_ram_unsigned_i,
  input  logic              flush_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [RAM_AW-1:0] dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  output logic [7:0]        dmem_wstrb_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic [4:0]        mem_rd_addr_o,
  output logic [XLEN-1:0]   mem_rd_data_o,
  output logic              mem_rd_wen_o,
  output logic              wb_valid_o,
  output logic              misalign_o
);

  import riscv_pkg::*;

  mem_state_t state_reg, state_next;
  logic       kill_reg, kill_next;

  // Instruction currently held in the stage.
  logic [4:0]        pend_rd_addr_reg;
  logic [XLEN-1:0]   pend_rd_data_reg;
  logic              pend_rd_wen_reg;
  logic              pend_we_reg;
  logic [RAM_AW-1:0] pend_addr_reg;
  logic [XLEN-1:0]   pend_wdata_reg;
  logic [1:0]        pend_size_reg;
  logic              pend_unsigned_reg;

  // Result shown to forwarding/WB; only loaded on entry to DONE so the
  // visible rd address/data hold their previous values while a memory
  // access is in flight.
  logic [4:0]        res_rd_addr_reg;
  logic [XLEN-1:0]   res_rd_data_reg;
  logic              res_rd_wen_reg;
  logic              res_misalign_reg;

  logic            accept;
  logic            ex_misaligned;
  logic            load_done;
  logic            store_done;
  logic            in_done;
  logic [XLEN-1:0] load_data;

  assign ex_ready_o    = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && !flush_i;
  assign accept        = ex_valid_i && ex_ready_o;
  assign ex_misaligned = ex_ram_req_i && is_misaligned(ex_ram_addr_i[2:0], ex_ram_size_i);

  // A load completes either in the grant cycle (rvalid together with gnt)
  // or later in RESP; a store completes on its grant.
  assign load_done  = (((state_reg == ST_REQ) && dmem_gnt_i) || (state_reg == ST_RESP))
                      && dmem_rvalid_i && !pend_we_reg;
  assign store_done = (state_reg == ST_REQ) && dmem_gnt_i && pend_we_reg;

  load_align_ext u_load_align_ext (
    .rdata    (dmem_rdata_i),
    .a        (pend_addr_reg[2:0]),
    .size     (pend_size_reg),
    .zero_ext (pend_unsigned_reg),
    .result   (load_data)
  );

  always_comb begin
    state_next = state_reg;
    kill_next  = kill_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        // kill belongs to the instruction leaving DONE; a new one starts clean.
        kill_next = 1'b0;
        if (accept) begin
          if (!ex_ram_req_i || ex_misaligned) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_REQ;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A flushed access still finishes its handshake; the request is
        // never withdrawn before gnt.
        if (flush_i) begin
          kill_next = 1'b1;
        end
        if (dmem_gnt_i) begin
          if (pend_we_reg || dmem_rvalid_i) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (flush_i) begin
          kill_next = 1'b1;
        end
        if (dmem_rvalid_i) begin
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        kill_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= ST_IDLE;
      kill_reg          <= 1'b0;
      pend_rd_addr_reg  <= '0;
      pend_rd_data_reg  <= '0;
      pend_rd_wen_reg   <= 1'b0;
      pend_we_reg       <= 1'b0;
      pend_addr_reg     <= '0;
      pend_wdata_reg    <= '0;
      pend_size_reg     <= '0;
      pend_unsigned_reg <= 1'b0;
      res_rd_addr_reg   <= '0;
      res_rd_data_reg   <= '0;
      res_rd_wen_reg    <= 1'b0;
      res_misalign_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      kill_reg  <= kill_next;

      if (accept) begin
        pend_rd_addr_reg  <= ex_rd_addr_i;
        pend_rd_data_reg  <= ex_rd_data_i;
        pend_rd_wen_reg   <= ex_rd_wen_i;
        pend_we_reg       <= ex_ram_we_i;
        pend_addr_reg     <= ex_ram_addr_i;
        pend_wdata_reg    <= ex_ram_wdata_i;
        pend_size_reg     <= ex_ram_size_i;
        pend_unsigned_reg <= ex_ram_unsigned_i;
        // Non-memory and misaligned ops go straight to DONE.
        if (!ex_ram_req_i || ex_misaligned) begin
          res_rd_addr_reg  <= ex_rd_addr_i;
          res_rd_data_reg  <= ex_rd_data_i;
          res_rd_wen_reg   <= ex_rd_wen_i;
          res_misalign_reg <= ex_misaligned;
        end
      end

      if (load_done) begin
        res_rd_addr_reg  <= pend_rd_addr_reg;
        res_rd_data_reg  <= load_data;
        res_rd_wen_reg   <= pend_rd_wen_reg;
        res_misalign_reg <= 1'b0;
      end else if (store_done) begin
        res_rd_addr_reg  <= pend_rd_addr_reg;
        res_rd_data_reg  <= pend_rd_data_reg;
        res_rd_wen_reg   <= pend_rd_wen_reg;
        res_misalign_reg <= 1'b0;
      end
    end
  end

  // Memory-side outputs; address, data and strobe come from registers so
  // they stay stable for the whole REQ phase.
  assign dmem_req_o   = (state_reg == ST_REQ);
  assign dmem_we_o    = dmem_req_o && pend_we_reg;
  assign dmem_addr_o  = {pend_addr_reg[RAM_AW-1:3], 3'b000};
  assign dmem_wstrb_o = dmem_we_o ? store_strobe(pend_addr_reg[2:0], pend_size_reg) : 8'h00;

  // Store data replicated across all byte lanes so the strobe alone picks
  // the destination lanes.
  for (genvar gi = 0; gi < 8; gi++) begin : g_wdata_lane
    assign dmem_wdata_o[8*gi +: 8] =
        (pend_size_reg == SZ_B) ? pend_wdata_reg[7:0] :
        (pend_size_reg == SZ_H) ? pend_wdata_reg[8*(gi % 2) +: 8] :
        (pend_size_reg == SZ_W) ? pend_wdata_reg[8*(gi % 4) +: 8] :
                                  pend_wdata_reg[8*gi +: 8];
  end

  assign in_done       = (state_reg == ST_DONE);
  assign mem_rd_addr_o = res_rd_addr_reg;
  assign mem_rd_data_o = res_rd_data_reg;
  assign misalign_o    = in_done && res_misalign_reg;
  assign wb_valid_o    = in_done && !kill_reg && !res_misalign_reg;
  assign mem_rd_wen_o  = wb_valid_o && res_rd_wen_reg;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [4:0]  ex_rd_addr_i;
  logic [63:0] ex_rd_data_i;
  logic        ex_rd_wen_i;
  logic        ex_ram_req_i;
  logic        ex_ram_we_i;
  logic [63:0] ex_ram_addr_i;
  logic [63:0] ex_ram_wdata_i;
  logic [1:0]  ex_ram_size_i;
  logic        ex_ram_unsigned_i;
  logic        flush_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_wstrb_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;
  logic [4:0]  mem_rd_addr_o;
  logic [63:0] mem_rd_data_o;
  logic        mem_rd_wen_o;
  logic        wb_valid_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_valid_i        (ex_valid_i),
    .ex_ready_o        (ex_ready_o),
    .ex_rd_addr_i      (ex_rd_addr_i),
    .ex_rd_data_i      (ex_rd_data_i),
    .ex_rd_wen_i       (ex_rd_wen_i),
    .ex_ram_req_i      (ex_ram_req_i),
    .ex_ram_we_i       (ex_ram_we_i),
    .ex_ram_addr_i     (ex_ram_addr_i),
    .ex_ram_wdata_i    (ex_ram_wdata_i),
    .ex_ram_size_i     (ex_ram_size_i),
    .ex_ram_unsigned_i (ex_ram_unsigned_i),
    .flush_i           (flush_i),
    .dmem_req_o        (dmem_req_o),
    .dmem_we_o         (dmem_we_o),
    .dmem_addr_o       (dmem_addr_o),
    .dmem_wdata_o      (dmem_wdata_o),
    .dmem_wstrb_o      (dmem_wstrb_o),
    .dmem_gnt_i        (dmem_gnt_i),
    .dmem_rvalid_i     (dmem_rvalid_i),
    .dmem_rdata_i      (dmem_rdata_i),
    .mem_rd_addr_o     (mem_rd_addr_o),
    .mem_rd_data_o     (mem_rd_data_o),
    .mem_rd_wen_o      (mem_rd_wen_o),
    .wb_valid_o        (wb_valid_o),
    .misalign_o        (misalign_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        wen;
    bit          mis;
    bit          is_store;
  } ret_t;

  typedef struct {
    logic [63:0] addr;
    bit          we;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
  } bus_t;

  ret_t ret_q[$];
  bus_t bus_q[$];

  // Architectural byte memory seen by the model, and doubleword memory
  // served by the bus responder; both start from the same pattern.
  logic [7:0]  mmem [logic [63:0]];
  logic [63:0] bmem [logic [63:0]];

  function automatic logic [7:0] init_byte(input logic [63:0] a);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h5C;
  endfunction

  function automatic logic [7:0] model_byte(input logic [63:0] a);
    if (mmem.exists(a)) return mmem[a];
    return init_byte(a);
  endfunction

  function automatic logic [63:0] bus_read(input logic [63:0] a);
    logic [63:0] v;
    if (bmem.exists(a)) return bmem[a];
    for (int j = 0; j < 8; j++) v[8*j +: 8] = init_byte(a + 64'(j));
    return v;
  endfunction

  task automatic preload(input logic [63:0] a, input logic [63:0] v);
    bmem[a] = v;
    for (int j = 0; j < 8; j++) mmem[a + 64'(j)] = v[8*j +: 8];
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] a, input int n, input logic uns);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(model_byte(a + 64'(i))) << (8 * i));
    if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  // ---------------- stimulus ----------------
  task automatic issue(input int kind, input logic [4:0] rd, input logic [63:0] data,
                       input logic wen, input logic [63:0] addr, input logic [1:0] size,
                       input logic uns, input bit exp_out, input bit exp_bus);
    int   n;
    int   guard;
    bit   mis;
    ret_t r;
    bus_t b;
    @(negedge clk);
    ex_valid_i        = 1'b1;
    ex_rd_addr_i      = rd;
    ex_rd_data_i      = data;
    ex_rd_wen_i       = wen;
    ex_ram_req_i      = (kind != 0);
    ex_ram_we_i       = (kind == 2);
    ex_ram_addr_i     = addr;
    ex_ram_wdata_i    = data;
    ex_ram_size_i     = size;
    ex_ram_unsigned_i = uns;
    guard = 0;
    while (!ex_ready_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ex_ready_o) begin
      check("issue_ready_timeout", ex_ready_o, 1);
      ex_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ex_valid_i = 1'b0;

    n   = 1 << size;
    mis = (kind != 0) && ((addr % 64'(n)) != 0);
    r.rd       = rd;
    r.wen      = wen;
    r.mis      = mis;
    r.is_store = (kind == 2);
    r.data     = data;
    if (kind == 1 && !mis) r.data = model_load(addr, n, uns);
    if (kind == 2 && !mis) begin
      for (int i = 0; i < n; i++) mmem[addr + 64'(i)] = data[8*i +: 8];
    end
    if (exp_out) ret_q.push_back(r);
    if (kind != 0 && !mis && exp_bus) begin
      b.addr  = addr & ~64'h7;
      b.we    = (kind == 2);
      b.wstrb = 8'h00;
      for (int i = 0; i < n; i++) b.wstrb[addr[2:0] + 3'(i)] = 1'b1;
      for (int j = 0; j < 8; j++) b.wdata[8*j +: 8] = data[8*(j % n) +: 8];
      bus_q.push_back(b);
    end
  endtask

  // Waits (bounded) for the next retire/misalign pulse, noting whether EX
  // was ever offered ready while waiting.
  task automatic wait_retire(output int cycles, output bit stalled);
    cycles  = 0;
    stalled = 1'b1;
    @(negedge clk);
    while (!wb_valid_o && !misalign_o && cycles < 40) begin
      if (ex_ready_o) stalled = 1'b0;
      @(negedge clk);
      cycles++;
    end
    check("retire_seen", wb_valid_o | misalign_o, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dmem_req"}, dmem_req_o, 0);
    check({tag, "_wb_valid"}, wb_valid_o, 0);
    check({tag, "_rd_wen"}, mem_rd_wen_o, 0);
    check({tag, "_misalign"}, misalign_o, 0);
    check({tag, "_rd_data"}, mem_rd_data_o, 0);
    check({tag, "_rd_addr"}, mem_rd_addr_o, 0);
    check({tag, "_ex_ready"}, ex_ready_o, 1);
  endtask

  // ---------------- memory responder + bus monitor ----------------
  bit          resp_en   = 1'b1;
  bit          force_bus = 1'b0;
  int          gnt_lat   = -1;
  int          rv_lat    = -1;
  bit          req_seen  = 1'b0;
  int          gnt_cnt   = 0;
  bit          rd_pend   = 1'b0;
  int          rd_cnt    = 0;
  logic [63:0] rd_addr   = 64'd0;

  initial begin
    bus_t b;
    int   lat;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 64'd0;
    forever begin
      @(negedge clk);
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      if (!resp_en) begin
        req_seen = 1'b0;
        rd_pend  = 1'b0;
        if (force_bus) begin
          dmem_gnt_i    = 1'b1;
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i  = 64'hDEAD_BEEF_CAFE_F00D;
        end
      end else if (rd_pend) begin
        if (rd_cnt == 0) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i  = bus_read(rd_addr);
          rd_pend       = 1'b0;
        end else begin
          rd_cnt--;
        end
      end else if (dmem_req_o) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          gnt_cnt  = (gnt_lat < 0) ? int'($urandom_range(0, 3)) : gnt_lat;
        end
        if (gnt_cnt == 0) begin
          dmem_gnt_i = 1'b1;
          req_seen   = 1'b0;
          if (bus_q.size() == 0) begin
            check("bus_unexpected_req", dmem_req_o, 0);
          end else begin
            b = bus_q.pop_front();
            check("bus_addr", dmem_addr_o, b.addr);
            check("bus_we", dmem_we_o, b.we);
            if (b.we) begin
              check("bus_wstrb", dmem_wstrb_o, b.wstrb);
              check("bus_wdata", dmem_wdata_o, b.wdata);
            end
          end
          if (dmem_we_o) begin
            logic [63:0] v;
            v = bus_read(dmem_addr_o);
            for (int j = 0; j < 8; j++)
              if (dmem_wstrb_o[j]) v[8*j +: 8] = dmem_wdata_o[8*j +: 8];
            bmem[dmem_addr_o] = v;
          end else begin
            lat = (rv_lat < 0) ? int'($urandom_range(0, 2)) : rv_lat;
            if (lat == 0) begin
              dmem_rvalid_i = 1'b1;
              dmem_rdata_i  = bus_read(dmem_addr_o);
            end else begin
              rd_pend = 1'b1;
              rd_cnt  = lat - 1;
              rd_addr = dmem_addr_o;
            end
          end
        end else begin
          gnt_cnt--;
        end
      end
    end
  end

  // ---------------- retire monitor ----------------
  initial begin
    ret_t r;
    forever begin
      @(negedge clk);
      if (rst_n && (wb_valid_o || misalign_o)) begin
        if (ret_q.size() == 0) begin
          check("unexpected_retire", wb_valid_o | misalign_o, 0);
        end else begin
          r = ret_q.pop_front();
          check("ret_misalign", misalign_o, r.mis);
          check("ret_wb_valid", wb_valid_o, !r.mis);
          check("ret_wen", mem_rd_wen_o, r.wen && !r.mis);
          if (!r.mis) begin
            check("ret_rd_addr", mem_rd_addr_o, r.rd);
            if (!r.is_store) check("ret_rd_data", mem_rd_data_o, r.data);
          end
        end
      end else if (rst_n && mem_rd_wen_o) begin
        check("stray_wen", mem_rd_wen_o, 0);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int          cycles;
    bit          stalled;
    bit          saw_out;
    int          kind;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] stream_data [3];
    ret_t        r;

    ex_valid_i = 1'b0; ex_rd_addr_i = '0; ex_rd_data_i = '0; ex_rd_wen_i = 1'b0;
    ex_ram_req_i = 1'b0; ex_ram_we_i = 1'b0; ex_ram_addr_i = '0; ex_ram_wdata_i = '0;
    ex_ram_size_i = '0; ex_ram_unsigned_i = 1'b0; flush_i = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // ALU stream: three back-to-back ops, one result per cycle.
    stream_data[0] = 64'h11; stream_data[1] = 64'h22; stream_data[2] = 64'h33;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("stream_wen", mem_rd_wen_o, 1);
        check("stream_data", mem_rd_data_o, stream_data[i-1]);
      end
      if (i < 3) begin
        ex_valid_i = 1'b1; ex_rd_addr_i = 5'd5; ex_rd_data_i = stream_data[i];
        ex_rd_wen_i = 1'b1; ex_ram_req_i = 1'b0; ex_ram_we_i = 1'b0;
        check("stream_ready", ex_ready_o, 1);
        r.rd = 5'd5; r.data = stream_data[i]; r.wen = 1'b1; r.mis = 1'b0; r.is_store = 1'b0;
        ret_q.push_back(r);
      end else begin
        ex_valid_i = 1'b0;
      end
    end

    // LB at 0x1003: gnt after 2 cycles, rvalid 1 later.
    gnt_lat = 2; rv_lat = 1;
    preload(64'h1000, 64'h0000_0000_00FF_80FF);
    issue(1, 5'd7, 64'd0, 1'b1, 64'h1003, 2'd0, 1'b0, 1, 1);
    wait_retire(cycles, stalled);
    check("lb_latency", cycles, 4);
    check("lb_stall", stalled, 1);
    check("lb_zero", mem_rd_data_o, 64'h0);

    preload(64'h1000, 64'h0000_0000_FF00_0000);
    issue(1, 5'd7, 64'd0, 1'b1, 64'h1003, 2'd0, 1'b0, 1, 1);
    wait_retire(cycles, stalled);
    check("lb_sign", mem_rd_data_o, 64'hFFFF_FFFF_FFFF_FFFF);

    issue(1, 5'd8, 64'd0, 1'b1, 64'h1003, 2'd0, 1'b1, 1, 1);
    wait_retire(cycles, stalled);
    check("lbu_zero_ext", mem_rd_data_o, 64'hFF);

    // SH at 0x2006.
    gnt_lat = 1;
    issue(2, 5'd0, 64'hBEEF, 1'b0, 64'h2006, 2'd1, 1'b0, 1, 1);
    @(negedge clk);
    check("sh_req", dmem_req_o, 1);
    check("sh_wstrb", dmem_wstrb_o, 8'hC0);
    check("sh_wdata", dmem_wdata_o, 64'hBEEF_BEEF_BEEF_BEEF);
    check("sh_addr", dmem_addr_o, 64'h2000);
    wait_retire(cycles, stalled);
    check("sh_latency", cycles, 1);
    check("sh_wen", mem_rd_wen_o, 0);

    // Misaligned LW at 0x2002.
    issue(1, 5'd3, 64'd0, 1'b1, 64'h2002, 2'd2, 1'b0, 1, 1);
    @(negedge clk);
    check("lw_mis_pulse", misalign_o, 1);
    check("lw_mis_noreq", dmem_req_o, 0);
    check("lw_mis_wen", mem_rd_wen_o, 0);
    @(negedge clk);
    check("lw_mis_end", misalign_o, 0);
    check("lw_mis_noreq2", dmem_req_o, 0);

    // LD flushed in RESP: handshake completes, nothing retires.
    gnt_lat = 0; rv_lat = 3;
    issue(1, 5'd9, 64'd0, 1'b1, 64'h1008, 2'd3, 1'b0, 0, 1);
    @(negedge clk);
    check("ld_flush_req", dmem_req_o, 1);
    @(negedge clk);
    check("ld_flush_resp_ready", ex_ready_o, 0);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    saw_out = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (wb_valid_o || mem_rd_wen_o) saw_out = 1'b1;
    end
    check("ld_flush_no_wb", saw_out, 0);
    check("ld_flush_idle_ready", ex_ready_o, 1);
    check("ld_flush_bus_done", bus_q.size(), 0);
    issue(0, 5'd12, 64'h1234_5678, 1'b1, 64'd0, 2'd0, 1'b0, 1, 1);
    @(negedge clk);
    check("after_flush_wen", mem_rd_wen_o, 1);

    // Reset while in REQ, then bus activity at release.
    gnt_lat = 20;
    issue(1, 5'd4, 64'd0, 1'b1, 64'h1010, 2'd3, 1'b0, 0, 0);
    @(negedge clk);
    check("rst_req_before", dmem_req_o, 1);
    rst_n   = 1'b0;
    resp_en = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_in_req");
    force_bus = 1'b1;
    rst_n     = 1'b1;
    saw_out   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (dmem_req_o || wb_valid_o || mem_rd_wen_o || misalign_o || !ex_ready_o) saw_out = 1'b1;
    end
    check("rst_release_no_change", saw_out, 0);
    force_bus = 1'b0;
    @(negedge clk);
    resp_en = 1'b1;
    gnt_lat = -1; rv_lat = -1;

    // Randomized mix against the model.
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 2);
      size = 2'($urandom_range(0, 3));
      addr = 64'h1000 + 64'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) addr = addr & ~((64'd1 << size) - 64'd1);
      issue(kind, 5'($urandom_range(0, 31)), {$urandom, $urandom},
            (kind == 2) ? 1'b0 : 1'($urandom_range(0, 1)), addr, size,
            1'($urandom_range(0, 1)), 1, 1);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    cycles = 0;
    while ((ret_q.size() != 0 || bus_q.size() != 0) && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    repeat (2) @(negedge clk);
    check("drain_retire_q", ret_q.size(), 0);
    check("drain_bus_q", bus_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
